// File: rtl/regfile_mp_scoreboard_if.sv
// Bus bundle for regfile_mp_scoreboard: read ports, two write ports and the
// load scoreboard controls/status. Widths must match the DUT parameters.
interface regfile_mp_scoreboard_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_READ   = 3,
   parameter int CNT_WIDTH  = 6
);
   logic [NUM_READ*ADDR_WIDTH-1:0] RA;
   logic [NUM_READ*DATA_WIDTH-1:0] RD;
   logic [NUM_READ-1:0]            BUSY_R;
   logic                           WE0;
   logic [ADDR_WIDTH-1:0]          WA0;
   logic [DATA_WIDTH-1:0]          WD0;
   logic                           WE1;
   logic [ADDR_WIDTH-1:0]          WA1;
   logic [DATA_WIDTH-1:0]          WD1;
   logic                           SB_SET;
   logic [ADDR_WIDTH-1:0]          SB_ADDR;
   logic [CNT_WIDTH-1:0]           PEND_CNT;
   logic                           SB_FULL;

   modport master (
      output RA, WE0, WA0, WD0, WE1, WA1, WD1, SB_SET, SB_ADDR,
      input  RD, BUSY_R, PEND_CNT, SB_FULL
   );

   modport slave (
      input  RA, WE0, WA0, WD0, WE1, WA1, WD1, SB_SET, SB_ADDR,
      output RD, BUSY_R, PEND_CNT, SB_FULL
   );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port register file (r0 = 0) with a per-register load busy scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by RF_BYPASS_EN.
module regfile_mp_scoreboard #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 32,
   parameter int NUM_READ   = 3,
   parameter int CNT_WIDTH  = 6
) (
   input logic                  CLK,
   input logic                  RST,
   regfile_mp_scoreboard_if.slave bus
);

   logic [DEPTH-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
   logic [DEPTH-1:0]                 busy_q, busy_d;
   logic [CNT_WIDTH-1:0]             pend_cnt_q, pend_cnt_d;
   logic                             sb_full_q, sb_full_d;

   logic [NUM_READ-1:0][ADDR_WIDTH-1:0] ra_v;
   logic [NUM_READ-1:0][DATA_WIDTH-1:0] rd_v;
   logic [NUM_READ-1:0]                 busy_v;

`ifdef RF_BYPASS_EN
   function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
      return (a != '0) && ({1'b0, a} < (ADDR_WIDTH+1)'(DEPTH));
   endfunction
`endif

   // Port 1 is applied after port 0 so it wins a collision; the set is applied
   // last so a newly issued load beats the clear of the previous one.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      for (int r = 1; r < DEPTH; r++) begin
         if (bus.WE0 && bus.WA0 == ADDR_WIDTH'(r))
            regs_d[r] = bus.WD0;
         if (bus.WE1 && bus.WA1 == ADDR_WIDTH'(r)) begin
            regs_d[r] = bus.WD1;
            busy_d[r] = 1'b0;
         end
         if (bus.SB_SET && bus.SB_ADDR == ADDR_WIDTH'(r))
            busy_d[r] = 1'b1;
      end
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
   end

   // Count is the population of the next busy vector, so it can never drift.
   always_comb begin
      pend_cnt_d = '0;
      for (int r = 1; r < DEPTH; r++)
         pend_cnt_d = pend_cnt_d + CNT_WIDTH'(busy_d[r]);
      sb_full_d = (pend_cnt_d == CNT_WIDTH'(DEPTH - 1));
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         regs_q     <= '0;
         busy_q     <= '0;
         pend_cnt_q <= '0;
         sb_full_q  <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         busy_q     <= busy_d;
         pend_cnt_q <= pend_cnt_d;
         sb_full_q  <= sb_full_d;
      end
   end

   assign ra_v = bus.RA;

   // Entry 0 of regs_q/busy_q is held at zero, so addresses 0 and >= DEPTH
   // both fall out of this mux as zero.
   always_comb begin
      rd_v   = '0;
      busy_v = '0;
      for (int k = 0; k < NUM_READ; k++) begin
         for (int r = 0; r < DEPTH; r++) begin
            if (ra_v[k] == ADDR_WIDTH'(r)) begin
               rd_v[k]   = regs_q[r];
               busy_v[k] = busy_q[r];
            end
         end
`ifdef RF_BYPASS_EN
         if (!RST && addr_ok(ra_v[k])) begin
            if (bus.WE1 && bus.WA1 == ra_v[k]) begin
               rd_v[k] = bus.WD1;
               if (!(bus.SB_SET && bus.SB_ADDR == ra_v[k]))
                  busy_v[k] = 1'b0;
            end else if (bus.WE0 && bus.WA0 == ra_v[k]) begin
               rd_v[k] = bus.WD0;
            end
         end
`endif
      end
   end

   assign bus.RD       = rd_v;
   assign bus.BUSY_R   = busy_v;
   assign bus.PEND_CNT = pend_cnt_q;
   assign bus.SB_FULL  = sb_full_q;

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Scoreboard bench: stimulus queues expected outputs, a negedge monitor checks them.
module tb_regfile_mp_scoreboard;

   logic clk = 1'b0;
   logic rst;

   regfile_mp_scoreboard_if bus ();

   regfile_mp_scoreboard dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   localparam int K_RD = 0, K_BUSY = 1, K_CNT = 2, K_FULL = 3;

   typedef struct {
      string       name;
      int          kind;
      int          port;
      logic [31:0] val;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        e;
   logic [31:0] act;
   int          n_pass  = 0;
   int          n_total = 0;

   task automatic expect_v(input string name, input int kind, input int port,
                           input logic [31:0] val);
      exp_t x;
      x.name = name;
      x.kind = kind;
      x.port = port;
      x.val  = val;
      exp_q.push_back(x);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      bus.WE0    = 1'b0;
      bus.WE1    = 1'b0;
      bus.SB_SET = 1'b0;
   endtask

   task automatic set_ra(input int a0, input int a1, input int a2);
      bus.RA = {5'(a2), 5'(a1), 5'(a0)};
   endtask

   task automatic wr0(input int a, input logic [31:0] d);
      bus.WE0 = 1'b1;
      bus.WA0 = 5'(a);
      bus.WD0 = d;
   endtask

   task automatic wr1(input int a, input logic [31:0] d);
      bus.WE1 = 1'b1;
      bus.WA1 = 5'(a);
      bus.WD1 = d;
   endtask

   task automatic sb_set(input int a);
      bus.SB_SET  = 1'b1;
      bus.SB_ADDR = 5'(a);
   endtask

   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         case (e.kind)
            K_RD:    act = bus.RD[e.port*32 +: 32];
            K_BUSY:  act = {31'b0, bus.BUSY_R[e.port]};
            K_CNT:   act = 32'(bus.PEND_CNT);
            default: act = {31'b0, bus.SB_FULL};
         endcase
         n_total++;
         if (act === e.val) n_pass++;
         else $display("FAIL %s: got 0x%0h, want 0x%0h", e.name, act, e.val);
      end
   end

   initial begin
      rst = 1'b1;
      bus.RA = '0;
      bus.WE0 = 1'b0; bus.WA0 = '0; bus.WD0 = '0;
      bus.WE1 = 1'b0; bus.WA1 = '0; bus.WD1 = '0;
      bus.SB_SET = 1'b0; bus.SB_ADDR = '0;

      next_cycle();
      for (int k = 0; k < 3; k++) expect_v("reset_rd", K_RD, k, 32'h0);
      expect_v("reset_busy", K_BUSY, 0, 32'h0);
      expect_v("reset_cnt", K_CNT, 0, 32'd0);
      expect_v("reset_full", K_FULL, 0, 32'd0);

      next_cycle();
      rst = 1'b0;
      wr0(5, 32'hDEADBEEF);
      sb_set(2);

      next_cycle();
      set_ra(5, 2, 0);
      expect_v("wr_r5", K_RD, 0, 32'hDEADBEEF);
      expect_v("busy_r2", K_BUSY, 1, 32'h1);
      expect_v("cnt_one", K_CNT, 0, 32'd1);

      // reset raised mid-cycle with a write and a set pending
      next_cycle();
      wr0(5, 32'h77);
      sb_set(3);
      #2 rst = 1'b1;
      expect_v("rst_mid_rd", K_RD, 0, 32'h0);
      expect_v("rst_mid_busy", K_BUSY, 1, 32'h0);
      expect_v("rst_mid_cnt", K_CNT, 0, 32'd0);
      expect_v("rst_mid_full", K_FULL, 0, 32'd0);

      next_cycle();
      rst = 1'b0;
      expect_v("rst_discard_rd", K_RD, 0, 32'h0);
      expect_v("rst_discard_cnt", K_CNT, 0, 32'd0);

      next_cycle();
      set_ra(0, 0, 0);
      wr0(0, 32'h12345678);
      next_cycle();
      for (int k = 0; k < 3; k++) expect_v("zero_reg", K_RD, k, 32'h0);

      next_cycle();
      wr0(7, 32'h11);
      wr1(7, 32'h22);
      next_cycle();
      wr0(6, 32'h66);
      set_ra(7, 0, 0);
      expect_v("collision", K_RD, 0, 32'h22);
      next_cycle();
      set_ra(7, 6, 0);
      expect_v("wr0_r6", K_RD, 1, 32'h66);

      next_cycle();
      sb_set(9);
      next_cycle();
      set_ra(9, 0, 0);
      expect_v("sb_busy9", K_BUSY, 0, 32'h1);
      expect_v("sb_cnt1", K_CNT, 0, 32'd1);
      next_cycle();
      wr1(9, 32'hAB);
      set_ra(0, 0, 0);
      next_cycle();
      set_ra(9, 0, 0);
      expect_v("clr_busy9", K_BUSY, 0, 32'h0);
      expect_v("clr_cnt0", K_CNT, 0, 32'd0);
      expect_v("clr_rd9", K_RD, 0, 32'hAB);

      next_cycle();
      sb_set(10);
      next_cycle();
      wr0(10, 32'h10);
      sb_set(4);
      next_cycle();
      set_ra(10, 4, 0);
      expect_v("wr0_keeps_busy", K_BUSY, 0, 32'h1);
      expect_v("wr0_data10", K_RD, 0, 32'h10);
      expect_v("race_busy_same", K_BUSY, 1, 32'h1);
      expect_v("cnt_two", K_CNT, 0, 32'd2);
      sb_set(4);
      wr1(4, 32'h44);
      next_cycle();
      expect_v("race_busy4", K_BUSY, 1, 32'h1);
      expect_v("race_rd4", K_RD, 1, 32'h44);
      expect_v("race_cnt", K_CNT, 0, 32'd2);

      for (int r = 1; r <= 31; r++) begin
         next_cycle();
         if (r == 31) begin
            expect_v("cnt_30", K_CNT, 0, 32'd30);
            expect_v("not_full_30", K_FULL, 0, 32'd0);
         end
         sb_set(r);
         if (r == 1) wr0(3, 32'h33);
      end
      next_cycle();
      set_ra(3, 8, 31);
      expect_v("cnt_full", K_CNT, 0, 32'd31);
      expect_v("sb_full", K_FULL, 0, 32'd1);
      expect_v("busy_r31", K_BUSY, 2, 32'h1);

      next_cycle();
      wr1(3, 32'h55);
      wr0(8, 32'h88);
`ifdef RF_BYPASS_EN
      expect_v("byp_rd3", K_RD, 0, 32'h55);
      expect_v("byp_busy3", K_BUSY, 0, 32'h0);
      expect_v("byp_rd8", K_RD, 1, 32'h88);
`else
      expect_v("nobyp_rd3", K_RD, 0, 32'h33);
      expect_v("nobyp_busy3", K_BUSY, 0, 32'h1);
      expect_v("nobyp_rd8", K_RD, 1, 32'h0);
`endif
      expect_v("wr0_busy8", K_BUSY, 1, 32'h1);
      expect_v("byp_cnt", K_CNT, 0, 32'd31);

      next_cycle();
      expect_v("post_rd3", K_RD, 0, 32'h55);
      expect_v("post_busy3", K_BUSY, 0, 32'h0);
      expect_v("post_rd8", K_RD, 1, 32'h88);
      expect_v("post_cnt", K_CNT, 0, 32'd30);
      expect_v("post_full", K_FULL, 0, 32'd0);

      repeat (3) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_total++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
